// File: rtl/run_detector_pkg.sv
// run_detector_pkg
//   Shared definitions for the run detector.
//   - state_t : per-channel FSM state (IDLE, COUNT, DET), 2-bit encoding
//   - HIT_W   : width of the optional per-channel hit counter
package run_detector_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      DET   = 2'b10
   } state_t;

   localparam int HIT_W = 8;

endpackage

// File: rtl/run_detector_ch.sv
// run_detector_ch
//   One detector channel. It counts consecutive enabled cycles with x high.
//   When the run starts, it samples y to select the run threshold (LEN_A or LEN_B).
//   The channel enters DET once the run reaches that threshold.
//   Ports:
//     clk, rst     : clock and synchronous active-high reset
//     en           : advance enable; 0 holds all state
//     x            : run input
//     y            : mode select, sampled only in IDLE when a run starts
//     z            : detect flag (state == DET), registered
//     z_rise       : one-cycle pulse in the first cycle z is high
//     hit_cnt      : saturating count of z_rise pulses (only when
//                    RUN_DETECTOR_HITCNT_EN is defined)
module run_detector_ch
   import run_detector_pkg::*;
#(
   parameter int CNT_W = 4,
   parameter int LEN_A = 1,
   parameter int LEN_B = 2
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic x,
   input  logic y,
   output logic z,
   output logic z_rise
`ifdef RUN_DETECTOR_HITCNT_EN
   ,
   output logic [HIT_W-1:0] hit_cnt
`endif
);

   localparam logic [CNT_W-1:0] THR_A   = CNT_W'(LEN_A);
   localparam logic [CNT_W-1:0] THR_B   = CNT_W'(LEN_B);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] thr_q, thr_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] thr_new;
   logic             rise_q, rise_d;

   assign cnt_inc = cnt_q + ONE;
   assign thr_new = y ? THR_B : THR_A;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      if (en) begin
         if (!x) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  thr_d   = thr_new;
                  cnt_d   = ONE;
                  state_d = (thr_new == ONE) ? DET : COUNT;
               end
               COUNT: begin
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == thr_q) ? DET : COUNT;
               end
               DET: begin
                  // Saturate rather than wrap during long runs.
                  cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
                  state_d = DET;
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
      // The pulse is set only on a transition into DET. A held DET, including one held by en=0, clears it.
      rise_d = (state_d == DET) && (state_q != DET);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         thr_q   <= '0;
         rise_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         thr_q   <= thr_d;
         rise_q  <= rise_d;
      end
   end

   assign z      = (state_q == DET);
   assign z_rise = rise_q;

`ifdef RUN_DETECTOR_HITCNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt <= '0;
      end else if (rise_q && (hit_cnt != {HIT_W{1'b1}})) begin
         hit_cnt <= hit_cnt + HIT_W'(1);
      end
   end
`endif

endmodule

// File: rtl/run_detector.sv
// run_detector
//   CH independent run detectors. Each channel i sees x[i], y[i] and drives
//   z[i], z_rise[i]. The shared en freezes every channel.
//   Optional macro: RUN_DETECTOR_HITCNT_EN adds hit_cnt (CH*8 bits,
//   channel i at [8i+7:8i]) with a saturating z_rise count per channel.
//   Ports:
//     clk, rst : clock and synchronous active-high reset
//     en       : global advance enable
//     x, y     : per-channel run input and mode select
//     z        : per-channel detect flag (registered)
//     z_rise   : per-channel first-cycle-of-detect pulse
module run_detector
   import run_detector_pkg::*;
#(
   parameter int CH    = 4,
   parameter int CNT_W = 4,
   parameter int LEN_A = 1,
   parameter int LEN_B = 2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CH-1:0] x,
   input  logic [CH-1:0] y,
   output logic [CH-1:0] z,
   output logic [CH-1:0] z_rise
`ifdef RUN_DETECTOR_HITCNT_EN
   ,
   output logic [CH*HIT_W-1:0] hit_cnt
`endif
);

   if (CH < 1 || CH > 16) begin : g_bad_ch
      $error("run_detector: CH out of range 1..16");
   end
   if (CNT_W < 2 || CNT_W > 8) begin : g_bad_cnt_w
      $error("run_detector: CNT_W out of range 2..8");
   end
   if (LEN_A < 1 || LEN_A > (1 << CNT_W) - 1) begin : g_bad_len_a
      $error("run_detector: LEN_A out of range");
   end
   if (LEN_B < 1 || LEN_B > (1 << CNT_W) - 1) begin : g_bad_len_b
      $error("run_detector: LEN_B out of range");
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      run_detector_ch #(
         .CNT_W(CNT_W),
         .LEN_A(LEN_A),
         .LEN_B(LEN_B)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .x      (x[i]),
         .y      (y[i]),
         .z      (z[i]),
         .z_rise (z_rise[i])
`ifdef RUN_DETECTOR_HITCNT_EN
         ,
         .hit_cnt(hit_cnt[HIT_W*i +: HIT_W])
`endif
      );
   end

endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector
//   Bench for run_detector. It instantiates the default configuration (dut) and a
//   CNT_W=2, LEN_B=3 configuration (dut2).
//   Inputs are driven 1 time unit after each rising edge. Outputs are sampled at that same point.
//   When RUN_DETECTOR_HITCNT_EN is defined, hit_cnt is checked as well.
module tb_run_detector;

   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [CH-1:0] x   = '0;
   logic [CH-1:0] y   = '0;
   logic [CH-1:0] z0, r0, z1, r1;
`ifdef RUN_DETECTOR_HITCNT_EN
   logic [CH*8-1:0] h0, h1;
`endif

   always #5 clk = ~clk;

   run_detector dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z0), .z_rise(r0)
`ifdef RUN_DETECTOR_HITCNT_EN
      , .hit_cnt(h0)
`endif
   );

   run_detector #(.CH(4), .CNT_W(2), .LEN_A(1), .LEN_B(3)) dut2 (
      .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z1), .z_rise(r1)
`ifdef RUN_DETECTOR_HITCNT_EN
      , .hit_cnt(h1)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: per channel, track the length of the current enabled run and the threshold chosen from y when the run began.
   // z is simply "run length reached threshold".
   int            len_a [2] = '{1, 1};
   int            len_b [2] = '{2, 3};
   int            cmax  [2] = '{15, 3};
   int            m_run [2][CH];
   int            m_thr [2][CH];
   int            m_hit [2][CH];
   logic [CH-1:0] m_z   [2];
   logic [CH-1:0] m_rise[2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_z[d] = '0;
         m_rise[d] = '0;
         for (int i = 0; i < CH; i++) begin
            m_run[d][i] = 0; m_thr[d][i] = 0; m_hit[d][i] = 0;
         end
      end
   end

   task automatic model_edge(input logic r, input logic e,
                             input logic [CH-1:0] xv, input logic [CH-1:0] yv);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < CH; i++) begin
            if (r) begin
               m_run[d][i] = 0; m_thr[d][i] = 0; m_hit[d][i] = 0;
               m_z[d][i] = 1'b0; m_rise[d][i] = 1'b0;
            end else begin
               if (m_rise[d][i] && m_hit[d][i] < 255) m_hit[d][i]++;
               if (!e) begin
                  m_rise[d][i] = 1'b0;
               end else if (!xv[i]) begin
                  m_run[d][i] = 0; m_z[d][i] = 1'b0; m_rise[d][i] = 1'b0;
               end else begin
                  if (m_run[d][i] == 0) m_thr[d][i] = yv[i] ? len_b[d] : len_a[d];
                  m_run[d][i]++;
                  m_rise[d][i] = (m_run[d][i] >= m_thr[d][i]) && !m_z[d][i];
                  m_z[d][i] = (m_run[d][i] >= m_thr[d][i]);
               end
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic e,
                       input logic [CH-1:0] xv, input logic [CH-1:0] yv);
      logic [31:0] eh0, eh1;
      rst = r; en = e; x = xv; y = yv;
      @(posedge clk);
      #1;
      model_edge(r, e, xv, yv);
      check("dut_z", 32'(z0), 32'(m_z[0]));
      check("dut_z_rise", 32'(r0), 32'(m_rise[0]));
      check("dut2_z", 32'(z1), 32'(m_z[1]));
      check("dut2_z_rise", 32'(r1), 32'(m_rise[1]));
      eh0 = '0; eh1 = '0;
      for (int i = 0; i < CH; i++) begin
         eh0[8*i +: 8] = 8'(m_hit[0][i]);
         eh1[8*i +: 8] = 8'(m_hit[1][i]);
      end
`ifdef RUN_DETECTOR_HITCNT_EN
      check("dut_hit_cnt", h0, eh0);
      check("dut2_hit_cnt", h1, eh1);
`endif
   endtask

   typedef struct {
      logic          r;
      logic          e;
      logic [CH-1:0] xv;
      logic [CH-1:0] yv;
      logic [CH-1:0] ez;
      logic [CH-1:0] er;
   } vec_t;

   vec_t tbl[18];

   initial begin
      int rises;
      logic [CH-1:0] xr, yr;
      logic rr, er;

      // Expected outputs of the default dut. Each row is one enabled or frozen clock edge.
      tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[2]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
      tbl[3]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
      tbl[4]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[5]  = '{1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      tbl[6]  = '{1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
      tbl[7]  = '{1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
      tbl[8]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[9]  = '{1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      tbl[10] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[11] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
      tbl[12] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
      tbl[13] = '{1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0010, 4'b0000};
      tbl[14] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[15] = '{1'b0, 1'b1, 4'b1111, 4'b0101, 4'b1010, 4'b1010};
      tbl[16] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0101};
      tbl[17] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000};

      for (int k = 0; k < 18; k++) begin
         step(tbl[k].r, tbl[k].e, tbl[k].xv, tbl[k].yv);
         check($sformatf("tbl%0d_z", k), 32'(z0), 32'(tbl[k].ez));
         check($sformatf("tbl%0d_z_rise", k), 32'(r0), 32'(tbl[k].er));
      end

      // dut2 channel 2: LEN_B=3 with a long run. The counter must saturate at 3, and z_rise must fire only once.
      step(1'b1, 1'b0, 4'b0000, 4'b0000);
      rises = 0;
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 1'b1, 4'b0100, 4'b0100);
         if (r1[2]) rises++;
         check($sformatf("dut2_ch2_z_edge%0d", k), 32'(z1[2]), (k >= 3) ? 32'd1 : 32'd0);
         check($sformatf("dut2_ch2_cnt_edge%0d", k), 32'(dut2.g_ch[2].u_ch.cnt_q),
               (k < 3) ? 32'(k) : 32'd3);
      end
      check("dut2_ch2_rise_count", 32'(rises), 32'd1);

      // A run in COUNT is frozen by en=0 for 5 cycles with x low, then completes as if there had been no gap.
      step(1'b0, 1'b1, 4'b0000, 4'b0000);
      step(1'b0, 1'b1, 4'b0010, 4'b0010);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 4'b0000, 4'b0000);
      step(1'b0, 1'b1, 4'b0010, 4'b0000);
      check("gap_resume_z", 32'(z0[1]), 32'd1);
      check("gap_resume_z_rise", 32'(r0[1]), 32'd1);

      // Reset while every channel is in DET.
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'b1111, 4'b0000);
      check("all_det_z", 32'(z0), 32'hF);
      step(1'b1, 1'b1, 4'b1111, 4'b0000);
      check("rst_det_z", 32'(z0), 32'h0);
      check("rst_det_z_rise", 32'(r0), 32'h0);
`ifdef RUN_DETECTOR_HITCNT_EN
      check("rst_det_hit_cnt", h0, 32'h0);
`endif

      // Randomized traffic: runs on each channel, occasional freezes, and rare resets.
      for (int k = 0; k < 500; k++) begin
         rr = ($urandom_range(0, 59) == 0);
         er = ($urandom_range(0, 4) != 0);
         for (int i = 0; i < CH; i++) begin
            xr[i] = ($urandom_range(0, 3) != 0);
            yr[i] = 1'($urandom_range(0, 1));
         end
         step(rr, er, xr, yr);
      end

      // 300 single-cycle runs on channel 3 drive the hit counter into saturation.
      step(1'b1, 1'b0, 4'b0000, 4'b0000);
      for (int k = 0; k < 300; k++) begin
         step(1'b0, 1'b1, 4'b1000, 4'b0000);
         step(1'b0, 1'b1, 4'b0000, 4'b0000);
      end
      step(1'b0, 1'b1, 4'b0000, 4'b0000);
`ifdef RUN_DETECTOR_HITCNT_EN
      check("hit_cnt_saturated", h0, 32'hFF00_0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
